// File: rtl/prbs31_checker.sv
// prbs31_checker: self-synchronising PRBS31 (x^31 + x^28 + 1) serial receive checker with lock, error counting and loss-of-sync detection
module prbs31_checker #(
    parameter int LOCK_CNT = 64,
    parameter int WIN_LEN  = 256,
    parameter int LOSS_THR = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    input  logic        din_valid,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic        sync_loss
);
    localparam int WW  = $clog2(WIN_LEN);
    localparam int WEW = $clog2(LOSS_THR + 1);

    typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

    state_t          r_state, w_state_nx;
    logic [30:0]     r_hist, w_hist_nx;
    logic [4:0]      r_fill, w_fill_nx;
    logic [7:0]      r_match, w_match_nx;
    logic [WW-1:0]   r_win, w_win_nx;
    logic [WEW-1:0]  r_werr, w_werr_nx, w_werr_inc;
    logic [15:0]     r_errs, w_errs_nx;
    logic            r_pulse, w_pulse_nx, r_loss, w_loss_nx;
    logic            w_pred, w_err, w_wrap;

    assign w_pred     = r_hist[27] ^ r_hist[30];
    assign w_err      = din ^ w_pred;
    assign w_wrap     = r_win == WW'(WIN_LEN - 1);
    assign w_werr_inc = r_werr + WEW'(w_err);

    assign locked    = r_state == LOCKED;
    assign err_pulse = r_pulse;
    assign err_count = r_errs;
    assign sync_loss = r_loss;

    // state register; every piece of state moves together on an accepted bit
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= SEED;
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= '0;
            r_win   <= '0;
            r_werr  <= '0;
            r_errs  <= '0;
            r_pulse <= 1'b0;
            r_loss  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_hist  <= w_hist_nx;
            r_fill  <= w_fill_nx;
            r_match <= w_match_nx;
            r_win   <= w_win_nx;
            r_werr  <= w_werr_nx;
            r_errs  <= w_errs_nx;
            r_pulse <= w_pulse_nx;
            r_loss  <= w_loss_nx;
        end
    end

    // acquisition / tracking: seed from the line, verify, then flywheel on the prediction
    always_comb begin
        w_state_nx = r_state;
        w_hist_nx  = r_hist;
        w_fill_nx  = r_fill;
        w_match_nx = r_match;
        w_win_nx   = r_win;
        w_werr_nx  = r_werr;
        w_pulse_nx = 1'b0;
        w_loss_nx  = 1'b0;
        if (din_valid) begin
            case (r_state)
                SEED: begin
                    w_hist_nx = {r_hist[29:0], din};
                    w_fill_nx = r_fill + 5'd1;
                    if (r_fill == 5'd30) begin
                        w_state_nx = VERIFY;
                        w_fill_nx  = '0;
                        w_match_nx = '0;
                    end
                end
                VERIFY: begin
                    w_hist_nx = {r_hist[29:0], din};
                    if (r_hist == '0 || w_err) begin
                        w_state_nx = SEED;
                        w_fill_nx  = '0;
                    end else begin
                        w_match_nx = r_match + 8'd1;
                        if (r_match + 8'd1 == 8'(LOCK_CNT)) begin
                            w_state_nx = LOCKED;
                            w_win_nx   = '0;
                            w_werr_nx  = '0;
                        end
                    end
                end
                LOCKED: begin
                    w_hist_nx  = {r_hist[29:0], w_pred};
                    w_pulse_nx = w_err;
                    w_win_nx   = r_win + WW'(1);
                    w_werr_nx  = w_wrap ? '0 : w_werr_inc;
                    if (w_werr_inc == WEW'(LOSS_THR)) begin
                        w_loss_nx  = 1'b1;
                        w_state_nx = SEED;
                        w_fill_nx  = '0;
                    end
                end
                default: w_state_nx = SEED;
            endcase
        end
    end

    // error counter: clear has priority, otherwise saturating increment on each error
    always_comb begin
        w_errs_nx = clear ? 16'd0 : (w_pulse_nx && r_errs != 16'hFFFF) ? r_errs + 16'd1 : r_errs;
    end
endmodule

// File: tb/tb_prbs31_checker.sv
// tb_prbs31_checker: directed checks of lock, error counting, loss of sync and saturation
module tb_prbs31_checker;
    logic        clk = 1'b0, rst = 1'b0, din = 1'b0, valid = 1'b0, clear = 1'b0, sel = 1'b0;
    logic        m_valid, s_valid;
    logic        m_locked, m_pulse, m_loss, s_locked, s_pulse, s_loss;
    logic [15:0] m_count, s_count;
    logic [30:0] g;
    int          n_chk = 0, n_pass = 0;
    int          vcnt, lock_at, n_pulse, n_loss, cyc;
    logic        saw_lock;

    assign m_valid = valid & ~sel;
    assign s_valid = valid & sel;

    prbs31_checker u_dut (
        .clk(clk), .rst_n(rst), .din(din), .din_valid(m_valid), .clear(clear),
        .locked(m_locked), .err_pulse(m_pulse), .err_count(m_count), .sync_loss(m_loss)
    );

    prbs31_checker #(.LOCK_CNT(1), .WIN_LEN(4096), .LOSS_THR(4096)) u_sat (
        .clk(clk), .rst_n(rst), .din(din), .din_valid(s_valid), .clear(clear),
        .locked(s_locked), .err_pulse(s_pulse), .err_count(s_count), .sync_loss(s_loss)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic gen(input logic v, input logic f);
        logic b;
        if (v) begin
            b = g[27] ^ g[30];
            g = {g[29:0], b};
            din = b ^ f;
        end
        valid = v;
        @(posedge clk); #1;
        if (v) vcnt++;
    endtask

    task automatic zero_bit();
        din = 1'b0;
        valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        g = 31'd1;
        vcnt = 0;
    endtask

    initial begin
        g = 31'd1;
        vcnt = 0;
        #2 rst = 1'b1;
        #2;
        check("rst_locked", m_locked, 0);
        check("rst_pulse", m_pulse, 0);
        check("rst_count", m_count, 0);
        check("rst_loss", m_loss, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        lock_at = 0; n_pulse = 0;
        for (int i = 1; i <= 10000; i++) begin
            gen(1'b1, 1'b0);
            if (m_locked && lock_at == 0) lock_at = i;
            if (m_pulse) n_pulse++;
        end
        check("clean_lock_bit", lock_at, 95);
        check("clean_count", m_count, 0);
        check("clean_pulses", n_pulse, 0);

        gen(1'b1, 1'b1);
        check("flip_pulse", m_pulse, 1);
        n_pulse = 1; n_loss = 0; saw_lock = 1'b1;
        for (int i = 0; i < 100; i++) begin
            gen(1'b1, 1'b0);
            if (m_pulse) n_pulse++;
            if (m_loss) n_loss++;
            if (!m_locked) saw_lock = 1'b0;
        end
        check("flip_pulses", n_pulse, 1);
        check("flip_count", m_count, 1);
        check("flip_locked", saw_lock, 1);
        check("flip_loss", n_loss, 0);

        do_reset();
        saw_lock = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            zero_bit();
            if (m_locked) saw_lock = 1'b1;
        end
        check("zero_never_lock", saw_lock, 0);

        do_reset();
        lock_at = 0; cyc = 0;
        while (vcnt < 120 && cyc < 1000) begin
            gen(1'($urandom_range(1)), 1'b0);
            cyc++;
            if (m_locked && lock_at == 0) lock_at = vcnt;
        end
        check("gap_lock_bit", lock_at, 95);

        for (int i = 1; i <= 15; i++) gen(1'b1, 1'b1);
        check("loss15_locked", m_locked, 1);
        check("loss15_loss", m_loss, 0);
        gen(1'b1, 1'b1);
        check("loss16_loss", m_loss, 1);
        check("loss16_pulse", m_pulse, 1);
        check("loss16_locked", m_locked, 0);
        check("loss16_count", m_count, 16);
        gen(1'b0, 1'b0);
        check("loss_idle_loss", m_loss, 0);
        check("loss_idle_pulse", m_pulse, 0);
        clear = 1'b1;
        vcnt = 0;
        gen(1'b1, 1'b0);
        clear = 1'b0;
        check("clear_count", m_count, 0);
        check("clear_unlocked", m_locked, 0);
        while (!m_locked && vcnt < 400) gen(1'b1, 1'b0);
        check("relock_bit", vcnt, 95);

        n_loss = 0; saw_lock = 1'b1;
        for (int k = 0; k < 300; k++) begin
            gen(1'b1, 1'(k >= 241 && k <= 270));
            if (m_loss) n_loss++;
            if (!m_locked) saw_lock = 1'b0;
        end
        check("win_loss", n_loss, 0);
        check("win_locked", saw_lock, 1);
        check("win_count", m_count, 30);

        gen(1'b1, 1'b1);
        check("pre_rst_pulse", m_pulse, 1);
        #2 rst = 1'b1;
        #1;
        check("async_locked", m_locked, 0);
        check("async_pulse", m_pulse, 0);
        check("async_count", m_count, 0);
        check("async_loss", m_loss, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        sel = 1'b1;
        g = 31'd1;
        vcnt = 0;
        while (!s_locked && vcnt < 100) gen(1'b1, 1'b0);
        check("sat_lock_bit", vcnt, 32);
        n_loss = 0;
        for (int k = 0; k < 65550; k++) begin
            gen(1'b1, 1'(k % 4096 != 4095));
            if (s_loss) n_loss++;
        end
        check("sat_fffe", s_count, 16'hFFFE);
        gen(1'b1, 1'b1);
        check("sat_ffff", s_count, 16'hFFFF);
        for (int k = 0; k < 10; k++) gen(1'b1, 1'b1);
        check("sat_hold", s_count, 16'hFFFF);
        check("sat_pulse", s_pulse, 1);
        check("sat_locked", s_locked, 1);
        check("sat_no_loss", n_loss, 0);
        clear = 1'b1;
        gen(1'b1, 1'b1);
        clear = 1'b0;
        check("clear_vs_err_count", s_count, 0);
        check("clear_vs_err_pulse", s_pulse, 1);
        gen(1'b1, 1'b1);
        check("post_clear_count", s_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/prbs31_checker.md
# prbs31_checker

Serial PRBS31 (x^31 + x^28 + 1) receive checker that sits directly downstream of the PRBS31 generator and consumes its one-bit-per-cycle output stream. It self-synchronises to the incoming sequence, declares lock after a run of error-free bits, and then counts bit errors against a locally regenerated sequence. It also drops lock and re-acquires when the error density in a window exceeds a threshold.

## Interface
Parameters:
- LOCK_CNT, 64: consecutive matching bits required in VERIFY before lock (range 1..255).
- WIN_LEN, 256: length of the error-density window in LOCKED, in valid bits (power of two, 16..4096).
- LOSS_THR, 16: errors within one window that force loss of lock (1..WIN_LEN).

Ports:
- clk, input, 1: sole clock; all state changes on rising edge.
- rst_n, input, 1: reset. Asynchronous and active-high: 1 = reset, despite the name.
- din, input, 1: received PRBS bit. Expected ordering is the generator's output order, where bit n = bit(n-28) XOR bit(n-31).
- din_valid, input, 1: din is sampled only when this is 1. With din_valid = 0, all state holds.
- clear, input, 1: synchronous clear of err_count; does not affect lock state.
- locked, output, 1: 1 while in the LOCKED state.
- err_pulse, output, 1: one-cycle pulse per detected bit error while LOCKED.
- err_count, output, 16: saturating count of errors while LOCKED.
- sync_loss, output, 1: one-cycle pulse when the block leaves LOCKED because of error density.

## Operation
- History register hist[30:0]: hist[0] is the newest bit. Predicted bit p = hist[27] XOR hist[30].
- Every valid bit shifts into hist at hist[0]. Which bit is shifted in depends on state (below).
- State SEED (reset state):
  - Shift in din; increment fill counter 0..30.
  - On the 31st valid bit: go to VERIFY, match counter = 0.
- State VERIFY:
  - Shift in din; compare din with p.
  - Match: match counter +1. When it reaches LOCK_CNT, go to LOCKED with window counter and window error counter = 0.
  - Mismatch: go to SEED, fill counter = 0. hist keeps shifting.
  - All-zero guard: if hist == 0 when a valid bit is accepted, go to SEED regardless of the comparison. A constant-0 stream must never lock.
- State LOCKED:
  - Shift in p, not din (flywheel), so a single flipped bit counts as exactly one error.
  - din != p: err_pulse = 1, err_count +1, window error counter +1.
  - Window counter increments per valid bit and wraps at WIN_LEN; at the wrap the window error counter resets to 0.
  - When the window error counter reaches LOSS_THR (this includes the current error): sync_loss = 1, go to SEED, fill counter = 0. err_count is retained.
- err_count saturates at 16'hFFFF and never wraps.
- clear = 1 sets err_count to 0. If clear coincides with an error, clear wins and err_count = 0.
- States are never reached in any other order; no other transitions exist.

## Timing
- All outputs are registered and update on the clock edge that accepts the causing valid bit. They are visible in the following cycle.
- err_pulse and sync_loss are exactly one cycle wide. Both are 0 in any cycle following an edge with din_valid = 0.
- Lock latency from reset with a clean stream: locked rises after valid bit 31 + LOCK_CNT (bit 95 with defaults).
- Reset values: locked = 0, err_pulse = 0, err_count = 0, sync_loss = 0, state = SEED, hist = 0, all counters = 0.
- Reset asserted mid-operation: all of the above apply immediately and asynchronously. Acquisition restarts after release.
- Simultaneous error and window wrap: the error is counted into the closing window first, then the counter resets.
- Simultaneous sync_loss and err_pulse: both assert in the same cycle.

## Test plan
- Clean stream from a generator reset to lfsr = 1, din_valid = 1 every cycle -> locked = 1 after bit 95, err_count = 0 after 10000 bits.
- Locked, flip one bit at bit 500 -> exactly one err_pulse, err_count = 1, locked stays 1.
- din held at 0 for 1000 valid bits -> locked never asserts. Toggle din_valid randomly on a clean stream -> lock still occurs at valid bit 95.
- Locked, flip 16 bits within one 256-bit window -> sync_loss pulses on the 16th error, locked = 0, err_count = 16. Relock occurs 95 valid bits later.
- Locked, flip 15 bits in one window and 15 bits in the next -> no sync_loss, err_count = 30.
- Force err_count to 16'hFFFF via many errors; more errors -> count stays 16'hFFFF. Assert clear together with an error -> err_count = 0. Assert rst_n = 1 while locked -> all outputs 0 immediately.
